// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port memory: instruction fetch and
// load/store share one command port. Data has priority until fetch has been
// denied MAX_WAIT consecutive cycles, after which fetch wins once.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned AW       = 32
) (
    input  logic          clk,
    input  logic          rstn,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_be,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,

    output logic          m_en,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    owner_t      owner;
    logic [3:0]  wait_cnt;
    logic [31:0] i_hold;
    logic [31:0] d_hold;
    logic        fetch_pri;

    assign fetch_pri = (wait_cnt == 4'(MAX_WAIT));

    // Grant decision: data first unless fetch has starved; nothing during reset.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rstn) begin
            if (d_req && !(i_req && fetch_pri)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // Memory command taken from whichever requester won this cycle.
    always_comb begin
        m_en    = i_gnt | d_gnt;
        m_we    = d_gnt & d_we;
        m_addr  = d_gnt ? d_addr  : i_addr;
        m_be    = d_gnt ? d_be    : 4'hF;
        m_wdata = d_gnt ? d_wdata : '0;
    end

    // Starvation counter: consecutive cycles fetch asked and was refused.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (i_req && !i_gnt) begin
            if (!fetch_pri) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Read owner and rvalid flags for the access issued at this edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner    <= OWN_NONE;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else if (i_gnt) begin
            owner    <= OWN_FETCH;
            i_rvalid <= 1'b1;
            d_rvalid <= 1'b0;
        end else if (d_gnt && !d_we) begin
            owner    <= OWN_DATA;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b1;
        end else begin
            owner    <= OWN_NONE;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end
    end

    // Capture returned data so each rdata port holds its last read value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i_hold <= '0;
            d_hold <= '0;
        end else begin
            if (owner == OWN_FETCH) begin
                i_hold <= m_rdata;
            end
            if (owner == OWN_DATA) begin
                d_hold <= m_rdata;
            end
        end
    end

    // m_rdata arrives one cycle after the grant, so it is passed straight
    // through to the owner to keep read latency at one cycle.
    always_comb begin
        i_rdata = (owner == OWN_FETCH) ? m_rdata : i_hold;
        d_rdata = (owner == OWN_DATA)  ? m_rdata : d_hold;
    end

endmodule
